// File: rtl/seq_alu.sv
// Width-generic sequential ALU: single-cycle logic/add/shift/rotate ops and
// iterative signed MUL/DIV on operand magnitudes, with a start/busy/done handshake.
module seq_alu #(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           start,
    input  logic [3:0]     op,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] result,
    output logic           done,
    output logic           busy,
    output logic           div_zero,
    output logic           zero
);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_SHRA  = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_ROR   = 4'd9;
    localparam logic [3:0] OP_ROL   = 4'd10;
    localparam logic [3:0] OP_NEG   = 4'd11;
    localparam logic [3:0] OP_NOT   = 4'd12;
    localparam logic [3:0] OP_INCPC = 4'd13;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           stateQ, stateD;
    logic [2*W-1:0]   accQ, accD;
    logic [W-1:0]     magBQ, magBD;
    logic [SHW-1:0]   cntQ, cntD;
    logic             signAQ, signAD, signBQ, signBD;
    logic             isDivQ, isDivD;
    logic [2*W-1:0]   resultQ, resultD;
    logic             doneQ, doneD;
    logic             divZeroQ, divZeroD;
    logic             zeroQ;

    logic [W-1:0]     absA, absB;
    logic [SHW-1:0]   shAmt;
    logic [W-1:0]     loRes;
    logic             sext;
    logic [2*W-1:0]   singleRes;
    logic [W:0]       mulSum;
    logic [2*W-1:0]   mulStep, mulFix;
    logic [W-1:0]     divShift, quo, rem;
    logic [W:0]       divDiff;
    logic [2*W-1:0]   divStep, divFix;

    assign absA  = A[W-1] ? -A : A;
    assign absB  = B[W-1] ? -B : B;
    assign shAmt = B[SHW-1:0];

    // Single-cycle datapath; ADD/SUB/NEG sign-extend into the high half.
    always_comb begin
        loRes = '0;
        sext  = 1'b0;
        unique case (op)
            OP_AND:   loRes = A & B;
            OP_OR:    loRes = A | B;
            OP_ADD:   begin loRes = A + B; sext = 1'b1; end
            OP_SUB:   begin loRes = A - B; sext = 1'b1; end
            OP_SHR:   loRes = A >> shAmt;
            OP_SHRA:  loRes = $signed(A) >>> shAmt;
            OP_SHL:   loRes = A << shAmt;
            OP_ROR:   loRes = W'({A, A} >> shAmt);
            OP_ROL:   loRes = W'(({A, A} << shAmt) >> W);
            OP_NEG:   begin loRes = -B; sext = 1'b1; end
            OP_NOT:   loRes = ~B;
            OP_INCPC: loRes = B + W'(4);
            default:  loRes = '0;
        endcase
        singleRes = {(sext ? {W{loRes[W-1]}} : {W{1'b0}}), loRes};
    end

    // acc holds {partial, operand}: shift-add for MUL, restoring {rem, quo} for DIV.
    always_comb begin
        mulSum   = {1'b0, accQ[2*W-1:W]} + (accQ[0] ? {1'b0, magBQ} : {(W+1){1'b0}});
        mulStep  = {mulSum, accQ[W-1:1]};
        divShift = {accQ[2*W-2:W], accQ[W-1]};
        divDiff  = {1'b0, divShift} - {1'b0, magBQ};
        divStep  = divDiff[W] ? {divShift, accQ[W-2:0], 1'b0}
                              : {divDiff[W-1:0], accQ[W-2:0], 1'b1};
        mulFix   = (signAQ ^ signBQ) ? -accQ : accQ;
        quo      = (signAQ ^ signBQ) ? -accQ[W-1:0] : accQ[W-1:0];
        rem      = signAQ ? -accQ[2*W-1:W] : accQ[2*W-1:W];
        divFix   = {rem, quo};
    end

    always_comb begin
        stateD   = stateQ;
        accD     = accQ;
        magBD    = magBQ;
        cntD     = cntQ;
        signAD   = signAQ;
        signBD   = signBQ;
        isDivD   = isDivQ;
        resultD  = resultQ;
        doneD    = 1'b0;
        divZeroD = divZeroQ;
        unique case (stateQ)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL || op == OP_DIV) begin
                        accD   = {{W{1'b0}}, absA};
                        magBD  = absB;
                        signAD = A[W-1];
                        signBD = B[W-1];
                        isDivD = (op == OP_DIV);
                        cntD   = '0;
                        // Divide by zero bypasses iteration with its answer preloaded.
                        if (op == OP_DIV && B == '0) begin
                            accD     = {A, {W{1'b1}}};
                            divZeroD = 1'b1;
                            stateD   = FIX;
                        end else begin
                            divZeroD = 1'b0;
                            stateD   = ITER;
                        end
                    end else begin
                        resultD  = singleRes;
                        doneD    = 1'b1;
                        divZeroD = 1'b0;
                    end
                end
            end
            ITER: begin
                accD = isDivQ ? divStep : mulStep;
                cntD = cntQ + SHW'(1);
                if (cntQ == SHW'(W - 1)) begin
                    stateD = FIX;
                end
            end
            FIX: begin
                resultD = divZeroQ ? accQ : (isDivQ ? divFix : mulFix);
                doneD   = 1'b1;
                stateD  = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            stateQ   <= IDLE;
            accQ     <= '0;
            magBQ    <= '0;
            cntQ     <= '0;
            signAQ   <= 1'b0;
            signBQ   <= 1'b0;
            isDivQ   <= 1'b0;
            resultQ  <= '0;
            doneQ    <= 1'b0;
            divZeroQ <= 1'b0;
            zeroQ    <= 1'b1;
        end else begin
            stateQ   <= stateD;
            accQ     <= accD;
            magBQ    <= magBD;
            cntQ     <= cntD;
            signAQ   <= signAD;
            signBQ   <= signBD;
            isDivQ   <= isDivD;
            resultQ  <= resultD;
            doneQ    <= doneD;
            divZeroQ <= divZeroD;
            zeroQ    <= (resultD == '0);
        end
    end

    assign result   = resultQ;
    assign done     = doneQ;
    assign busy     = (stateQ != IDLE);
    assign div_zero = divZeroQ;
    assign zero     = zeroQ;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=32): directed vector table, handshake and
// mid-operation reset sequences, and random ops against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clear;
    logic           start;
    logic [3:0]     op;
    logic [W-1:0]   A, B;
    logic [2*W-1:0] result;
    logic           done, busy, div_zero, zero;

    int compared   = 0;
    int mismatched = 0;

    seq_alu #(.W(W)) dut (
        .clk(clk), .clear(clear), .start(start), .op(op), .A(A), .B(B),
        .result(result), .done(done), .busy(busy), .div_zero(div_zero), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic        expDz;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Accepting edge happens inside; operands are scrambled afterwards.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        op = 4'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic waitDone(output int cycles, output int busyCnt);
        cycles = 0; busyCnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busyCnt++;
            tick();
            cycles++;
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        longint s;
        s = $signed(v);
        return s;
    endfunction

    // Reference model: plain signed arithmetic and bitwise rotation loops.
    function automatic logic [63:0] refResult(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] lo;
        int n;
        n = int'(b[4:0]);
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            4'd0:  return {32'h0, a & b};
            4'd1:  return {32'h0, a | b};
            4'd2:  return sx(a + b);
            4'd3:  return sx(a - b);
            4'd4:  return sa * sb;
            4'd5: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd6:  return {32'h0, a >> n};
            4'd7: begin
                lo = $signed(a) >>> n;
                return {32'h0, lo};
            end
            4'd8:  return {32'h0, a << n};
            4'd9: begin
                lo = a;
                repeat (n) lo = {lo[0], lo[31:1]};
                return {32'h0, lo};
            end
            4'd10: begin
                lo = a;
                repeat (n) lo = {lo[30:0], lo[31]};
                return {32'h0, lo};
            end
            4'd11: return sx(32'h0 - b);
            4'd12: return {32'h0, ~b};
            4'd13: return {32'h0, b + 32'd4};
            default: return 64'h0;
        endcase
    endfunction

    function automatic int refLatency(input logic [3:0] o, input logic [31:0] b);
        if (o == 4'd5 && b == 32'h0) return 1;
        if (o == 4'd4 || o == 4'd5) return W + 1;
        return 0;
    endfunction

    vec_t vecs[16];
    int   cyc, bcnt, doneSeen;

    initial begin
        vecs[0]  = '{4'd2,  32'h7FFF_FFFF, 32'h1,         64'hFFFF_FFFF_8000_0000, 1'b0, 0};
        vecs[1]  = '{4'd3,  32'h5,         32'h5,         64'h0,                   1'b0, 0};
        vecs[2]  = '{4'd4,  32'hFFFF_FFFD, 32'h7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33};
        vecs[3]  = '{4'd4,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33};
        vecs[4]  = '{4'd5,  32'hFFFF_FFEF, 32'h5,         64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 33};
        vecs[5]  = '{4'd5,  32'd100,       32'h0,         64'h0000_0064_FFFF_FFFF, 1'b1, 1};
        vecs[6]  = '{4'd9,  32'h1,         32'h1,         64'h0000_0000_8000_0000, 1'b0, 0};
        vecs[7]  = '{4'd10, 32'h1234_5678, 32'd32,        64'h0000_0000_1234_5678, 1'b0, 0};
        vecs[8]  = '{4'd7,  32'h8000_0000, 32'd4,         64'h0000_0000_F800_0000, 1'b0, 0};
        vecs[9]  = '{4'd6,  32'h8000_0000, 32'd4,         64'h0000_0000_0800_0000, 1'b0, 0};
        vecs[10] = '{4'd5,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33};
        vecs[11] = '{4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,                   1'b0, 0};
        vecs[12] = '{4'd13, 32'h0,         32'hFFFF_FFFE, 64'h0000_0000_0000_0002, 1'b0, 0};
        vecs[13] = '{4'd11, 32'h0,         32'h1,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0};
        vecs[14] = '{4'd12, 32'h0,         32'h0,         64'h0000_0000_FFFF_FFFF, 1'b0, 0};
        vecs[15] = '{4'd8,  32'h1,         32'd31,        64'h0000_0000_8000_0000, 1'b0, 0};

        clear = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        tick(); tick();
        checkOutput("reset.result",   result,   64'h0);
        checkOutput("reset.done",     done,     64'h0);
        checkOutput("reset.busy",     busy,     64'h0);
        checkOutput("reset.div_zero", div_zero, 64'h0);
        checkOutput("reset.zero",     zero,     64'h1);
        clear = 1'b0;
        tick();

        $display("[TB] directed vectors");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(cyc, bcnt);
            checkOutput($sformatf("vec%0d.done", i),     done,      64'h1);
            checkOutput($sformatf("vec%0d.latency", i),  cyc,       vecs[i].lat);
            checkOutput($sformatf("vec%0d.busycnt", i),  bcnt,      vecs[i].lat);
            checkOutput($sformatf("vec%0d.result", i),   result,    vecs[i].exp);
            checkOutput($sformatf("vec%0d.zero", i),     zero,      (vecs[i].exp == 64'h0));
            checkOutput($sformatf("vec%0d.div_zero", i), div_zero,  vecs[i].expDz);
            tick();
            checkOutput($sformatf("vec%0d.donedrop", i), done,      64'h0);
            checkOutput($sformatf("vec%0d.hold", i),     result,    vecs[i].exp);
        end

        $display("[TB] start ignored while busy, then back-to-back start");
        applyStimulus(4'd5, 32'hFFFF_FFEF, 32'h5);
        repeat (3) tick();
        applyStimulus(4'd2, 32'h1, 32'h2);
        waitDone(cyc, bcnt);
        checkOutput("busyign.latency", cyc + 4, 33);
        checkOutput("busyign.result",  result,  64'hFFFF_FFFE_FFFF_FFFD);
        tick();
        applyStimulus(4'd5, 32'd100, 32'h0);
        waitDone(cyc, bcnt);
        checkOutput("b2b.dz.result",   result,   64'h0000_0064_FFFF_FFFF);
        checkOutput("b2b.dz.div_zero", div_zero, 64'h1);
        applyStimulus(4'd2, 32'd3, 32'd4);
        checkOutput("b2b.add.done",     done,     64'h1);
        checkOutput("b2b.add.result",   result,   64'h7);
        checkOutput("b2b.add.div_zero", div_zero, 64'h0);

        $display("[TB] clear during MUL");
        tick();
        applyStimulus(4'd4, 32'hFFFF_FFFD, 32'h7);
        repeat (9) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("midclr.busy",   busy,   64'h0);
        checkOutput("midclr.done",   done,   64'h0);
        checkOutput("midclr.result", result, 64'h0);
        checkOutput("midclr.zero",   zero,   64'h1);
        doneSeen = 0;
        repeat (40) begin
            tick();
            if (done || busy) doneSeen++;
        end
        checkOutput("midclr.nodone", doneSeen, 0);
        applyStimulus(4'd4, 32'hFFFF_FFFD, 32'h7);
        waitDone(cyc, bcnt);
        checkOutput("midclr.rerun.latency", cyc,    33);
        checkOutput("midclr.rerun.result",  result, 64'hFFFF_FFFF_FFFF_FFEB);

        $display("[TB] random operations");
        for (int i = 0; i < 200; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h0;
                3: rb = 32'($urandom_range(0, 40));
                default: ;
            endcase
            applyStimulus(ro, ra, rb);
            waitDone(cyc, bcnt);
            checkOutput($sformatf("rnd%0d.op%0d.latency", i, ro), cyc,      refLatency(ro, rb));
            checkOutput($sformatf("rnd%0d.op%0d.result", i, ro),  result,   refResult(ro, ra, rb));
            checkOutput($sformatf("rnd%0d.op%0d.div_zero", i, ro), div_zero, (ro == 4'd5 && rb == 32'h0));
            checkOutput($sformatf("rnd%0d.op%0d.zero", i, ro),    zero,     (refResult(ro, ra, rb) == 64'h0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
